// File: rtl/mem_arbiter_if.sv
// Request/acknowledge and SRAM strobe/address bundle for mem_arbiter.
// Contents:
//   - fetch port:   if_mc_en, if_mc_addr, mc_if_data, mc_if_ack
//   - memory port:  mem_mc_en, mem_mc_rw, mem_mc_addr, mc_mem_ack
//   - pipeline:     mc_stall
//   - SRAM pins:    sram_addr, sram_ce_n, sram_oe_n, sram_we_n
// The bidirectional data buses stay plain inout ports on the arbiter.
// Modports:
//   - slave:  the arbiter side.
//   - master: the pipeline/bench side.
interface mem_arbiter_if;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;

  logic          if_mc_en;
  logic [AW-1:0] if_mc_addr;
  logic [DW-1:0] mc_if_data;
  logic          mc_if_ack;
  logic          mem_mc_en;
  logic          mem_mc_rw;
  logic [AW-1:0] mem_mc_addr;
  logic          mc_mem_ack;
  logic          mc_stall;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;

  modport slave (
    input  if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr,
    output mc_if_data, mc_if_ack, mc_mem_ack, mc_stall,
           sram_addr, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr,
    input  mc_if_data, mc_if_ack, mc_mem_ack, mc_stall,
           sram_addr, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port SRAM controller arbitrating between instruction fetch and the
// Memory stage. One access at a time; each access runs WAIT_STATES+1 strobe
// cycles, then a one-cycle DONE in which the owner's ack pulses.
// Ports:
//   - i_clk, i_rst_n:  clock, async active-low reset
//   - bus:             request/ack/stall/SRAM strobe bundle (slave modport)
//   - io_mem_mc_data:  Memory-stage data bus. The stage drives write data;
//                      read data is driven here while a read is requested.
//   - io_sram_data:    SRAM data bus. Write data is driven here from grant
//                      through DONE.
module mem_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mem_arbiter_if.slave       bus,
  inout  wire  [31:0]        io_mem_mc_data,
  inout  wire  [31:0]        io_sram_data
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned AW    = 18;
  localparam int unsigned DW    = 32;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t           r_state;
  logic             r_grant_mem;
  logic             r_last_mem;
  logic             r_rw;
  logic             r_drive;
  logic             r_if_ack;
  logic             r_mem_ack;
  logic             r_ce_n;
  logic             r_oe_n;
  logic             r_we_n;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_rdata;

  logic             w_pick_mem;
  logic             w_wr;

  // MEM wins a tie unless it also won the previous access (fetch anti-starvation).
  assign w_pick_mem = bus.mem_mc_en & (~bus.if_mc_en | ~r_last_mem);
  assign w_wr       = w_pick_mem & bus.mem_mc_rw;

  // Arbitration, access timing and read capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_grant_mem <= 1'b0;
      r_last_mem  <= 1'b0;
      r_rw        <= 1'b0;
      r_drive     <= 1'b0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.if_mc_en | bus.mem_mc_en) begin
            r_grant_mem <= w_pick_mem;
            r_addr      <= w_pick_mem ? bus.mem_mc_addr : bus.if_mc_addr;
            r_rw        <= w_wr;
            r_wdata     <= io_mem_mc_data;
            r_drive     <= w_wr;
            r_ce_n      <= 1'b0;
            r_oe_n      <= w_wr;
            r_we_n      <= ~w_wr;
            r_cnt       <= CNT_W'(WAIT_STATES);
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            // oe_n is still low on this edge, so the SRAM is still driving.
            if (!r_rw) r_rdata <= io_sram_data;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_if_ack  <= ~r_grant_mem;
            r_mem_ack <= r_grant_mem;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          // Write data is held through DONE for SRAM hold time.
          r_last_mem <= r_grant_mem;
          r_drive    <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sram_addr  = r_addr;
  assign bus.sram_ce_n  = r_ce_n;
  assign bus.sram_oe_n  = r_oe_n;
  assign bus.sram_we_n  = r_we_n;
  assign bus.mc_if_data = r_rdata;
  assign bus.mc_if_ack  = r_if_ack;
  assign bus.mc_mem_ack = r_mem_ack;

  // Freeze is released in DONE, so the pipeline advances on the edge ending it.
  assign bus.mc_stall = (bus.if_mc_en | bus.mem_mc_en) & (r_state != S_DONE);

  assign io_sram_data   = r_drive ? r_wdata : 'z;
  // Never driven while the stage itself drives write data.
  assign io_mem_mc_data = (bus.mem_mc_en & ~bus.mem_mc_rw) ? r_rdata : 'z;
endmodule
